// File: rtl/d_flip_flop.sv
// Parameterised D flip-flop with asynchronous active-high reset to RESET_VALUE.
// Defining D_FLIP_FLOP_QN_EN adds the inverted output qn after q.
module d_flip_flop #(
  parameter int unsigned           WIDTH       = 1,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic [WIDTH-1:0] d,
  input  logic             clk,
  input  logic             reset,
`ifdef D_FLIP_FLOP_QN_EN
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn
`else
  output logic [WIDTH-1:0] q
`endif
);

  // Reset is in the sensitivity list, so it overrides a clk edge in the same time step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= RESET_VALUE;
    end else begin
      q <= d;
    end
  end

`ifdef D_FLIP_FLOP_QN_EN
  assign qn = ~q;
`endif

endmodule

// File: tb/tb_d_flip_flop.sv
// Scoreboard bench for d_flip_flop: a 1-bit instance and an 8-bit instance with RESET_VALUE 8'hA5.
// Clock period 20 with rising edges at 10, 30, 50, ...
`timescale 1ns/1ps
module tb_d_flip_flop;

  logic       clk = 1'b0;
  logic       reset;
  logic       d;
  logic       q;
  logic       resetW;
  logic [7:0] dW;
  logic [7:0] qW;
`ifdef D_FLIP_FLOP_QN_EN
  logic       qn;
  logic [7:0] qnW;
`endif

  logic       expQ[$];
  logic [7:0] expWQ[$];
  logic       exp1;
  logic [7:0] exp8;
  int         checks   = 0;
  int         failures = 0;

  d_flip_flop dut (
    .d     (d),
    .clk   (clk),
    .reset (reset),
`ifdef D_FLIP_FLOP_QN_EN
    .q     (q),
    .qn    (qn)
`else
    .q     (q)
`endif
  );

  d_flip_flop #(.WIDTH(8), .RESET_VALUE(8'hA5)) dutW (
    .d     (dW),
    .clk   (clk),
    .reset (resetW),
`ifdef D_FLIP_FLOP_QN_EN
    .q     (qW),
    .qn    (qnW)
`else
    .q     (qW)
`endif
  );

  always #10 clk = ~clk;

  // Starts at t=0: both resets high, d toggles every 20, outputs must stay at reset values.
  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      d  = i[0];
      dW = {8{i[0]}};
      expQ.push_back(1'b0);
      expWQ.push_back(8'hA5);
      #15;
      exp1 = expQ.pop_front();
      checks++;
      if (q !== exp1) begin failures++; $display("[TB] FAIL reset_hold t=%0t q=%b expected %b", $time, q, exp1); end
      exp8 = expWQ.pop_front();
      checks++;
      if (qW !== exp8) begin failures++; $display("[TB] FAIL reset_hold_wide t=%0t q=%h expected %h", $time, qW, exp8); end
`ifdef D_FLIP_FLOP_QN_EN
      checks++;
      if (qn !== ~exp1) begin failures++; $display("[TB] FAIL reset_hold_qn t=%0t qn=%b expected %b", $time, qn, ~exp1); end
      checks++;
      if (qnW !== ~exp8) begin failures++; $display("[TB] FAIL reset_hold_qn_wide t=%0t qn=%h expected %h", $time, qnW, ~exp8); end
`endif
      #5;
    end
  endtask

  // Starts at t=80: release with d=1, q must wait for the edge at 90.
  task automatic test_release();
    reset = 1'b0;
    d     = 1'b1;
    expQ.push_back(1'b0);
    #5;
    exp1 = expQ.pop_front();
    checks++;
    if (q !== exp1) begin failures++; $display("[TB] FAIL release_no_change t=%0t q=%b expected %b", $time, q, exp1); end
    expQ.push_back(1'b1);
    #10;
    exp1 = expQ.pop_front();
    checks++;
    if (q !== exp1) begin failures++; $display("[TB] FAIL release_first_edge t=%0t q=%b expected %b", $time, q, exp1); end
`ifdef D_FLIP_FLOP_QN_EN
    checks++;
    if (qn !== ~exp1) begin failures++; $display("[TB] FAIL release_qn t=%0t qn=%b expected %b", $time, qn, ~exp1); end
`endif
  endtask

  // Starts at t=95: captures on rising edges only, ignores glitches and falling edges.
  task automatic test_capture();
    #5 d = 1'b1;
    expQ.push_back(1'b1);
    #15;
    exp1 = expQ.pop_front();
    checks++;
    if (q !== exp1) begin failures++; $display("[TB] FAIL capture_one t=%0t q=%b expected %b", $time, q, exp1); end
    #5 d = 1'b0;
    #5 d = 1'b1;
    #3 d = 1'b0;
    expQ.push_back(1'b1);
    #1;
    exp1 = expQ.pop_front();
    checks++;
    if (q !== exp1) begin failures++; $display("[TB] FAIL hold_between_edges t=%0t q=%b expected %b", $time, q, exp1); end
    expQ.push_back(1'b0);
    #6;
    exp1 = expQ.pop_front();
    checks++;
    if (q !== exp1) begin failures++; $display("[TB] FAIL capture_zero t=%0t q=%b expected %b", $time, q, exp1); end
`ifdef D_FLIP_FLOP_QN_EN
    checks++;
    if (qn !== ~exp1) begin failures++; $display("[TB] FAIL capture_zero_qn t=%0t qn=%b expected %b", $time, qn, ~exp1); end
`endif
    #5 d = 1'b1;
    expQ.push_back(1'b0);
    #5;
    exp1 = expQ.pop_front();
    checks++;
    if (q !== exp1) begin failures++; $display("[TB] FAIL hold_falling_edge t=%0t q=%b expected %b", $time, q, exp1); end
    expQ.push_back(1'b1);
    #10;
    exp1 = expQ.pop_front();
    checks++;
    if (q !== exp1) begin failures++; $display("[TB] FAIL capture_before_reset t=%0t q=%b expected %b", $time, q, exp1); end
  endtask

  // Starts at t=155: reset at 160 mid-period clears q at once and holds through edges.
  task automatic test_async_reset();
    #5 reset = 1'b1;
    expQ.push_back(1'b0);
    #1;
    exp1 = expQ.pop_front();
    checks++;
    if (q !== exp1) begin failures++; $display("[TB] FAIL async_reset_immediate t=%0t q=%b expected %b", $time, q, exp1); end
`ifdef D_FLIP_FLOP_QN_EN
    checks++;
    if (qn !== ~exp1) begin failures++; $display("[TB] FAIL async_reset_qn t=%0t qn=%b expected %b", $time, qn, ~exp1); end
`endif
    #4 d = 1'b0;
    #15 d = 1'b1;
    expQ.push_back(1'b0);
    #5;
    exp1 = expQ.pop_front();
    checks++;
    if (q !== exp1) begin failures++; $display("[TB] FAIL reset_ignores_d t=%0t q=%b expected %b", $time, q, exp1); end
    expQ.push_back(1'b0);
    #10;
    exp1 = expQ.pop_front();
    checks++;
    if (q !== exp1) begin failures++; $display("[TB] FAIL reset_ignores_edge t=%0t q=%b expected %b", $time, q, exp1); end
    #5;
    reset = 1'b0;
    d     = 1'b1;
    expQ.push_back(1'b1);
    #15;
    exp1 = expQ.pop_front();
    checks++;
    if (q !== exp1) begin failures++; $display("[TB] FAIL recapture_after_reset t=%0t q=%b expected %b", $time, q, exp1); end
  endtask

  // Starts at t=215: reset rises in the same time step as the edge at 230 with d=1.
  task automatic test_reset_wins_edge();
    #15 reset = 1'b1;
    expQ.push_back(1'b0);
    #1;
    exp1 = expQ.pop_front();
    checks++;
    if (q !== exp1) begin failures++; $display("[TB] FAIL reset_wins_edge t=%0t q=%b expected %b", $time, q, exp1); end
    #9;
  endtask

  // Starts at t=240: 8-bit instance, release, capture two patterns, then mid-run reset.
  task automatic test_wide();
    expWQ.push_back(8'hA5);
    #1;
    exp8 = expWQ.pop_front();
    checks++;
    if (qW !== exp8) begin failures++; $display("[TB] FAIL wide_reset_value t=%0t q=%h expected %h", $time, qW, exp8); end
    #4;
    resetW = 1'b0;
    dW     = 8'h3C;
    expWQ.push_back(8'hA5);
    #2;
    exp8 = expWQ.pop_front();
    checks++;
    if (qW !== exp8) begin failures++; $display("[TB] FAIL wide_release_hold t=%0t q=%h expected %h", $time, qW, exp8); end
    expWQ.push_back(8'h3C);
    #8;
    exp8 = expWQ.pop_front();
    checks++;
    if (qW !== exp8) begin failures++; $display("[TB] FAIL wide_capture_3c t=%0t q=%h expected %h", $time, qW, exp8); end
`ifdef D_FLIP_FLOP_QN_EN
    checks++;
    if (qnW !== ~exp8) begin failures++; $display("[TB] FAIL wide_qn_3c t=%0t qn=%h expected %h", $time, qnW, ~exp8); end
`endif
    #5 dW = 8'hC3;
    expWQ.push_back(8'hC3);
    #15;
    exp8 = expWQ.pop_front();
    checks++;
    if (qW !== exp8) begin failures++; $display("[TB] FAIL wide_capture_c3 t=%0t q=%h expected %h", $time, qW, exp8); end
    #5 resetW = 1'b1;
    expWQ.push_back(8'hA5);
    #1;
    exp8 = expWQ.pop_front();
    checks++;
    if (qW !== exp8) begin failures++; $display("[TB] FAIL wide_async_reset t=%0t q=%h expected %h", $time, qW, exp8); end
`ifdef D_FLIP_FLOP_QN_EN
    checks++;
    if (qnW !== ~exp8) begin failures++; $display("[TB] FAIL wide_qn_reset t=%0t qn=%h expected %h", $time, qnW, ~exp8); end
`endif
  endtask

  initial begin
    reset  = 1'b1;
    resetW = 1'b1;
    d      = 1'b0;
    dW     = 8'h00;
    test_reset();
    test_release();
    test_capture();
    test_async_reset();
    test_reset_wins_edge();
    test_wide();
    checks++;
    if (expQ.size() != 0 || expWQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain left=%0d expected 0", expQ.size() + expWQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
